// File: rtl/viterbi_pkg.sv
// Shared constants, types and the branch-label function for the K=3 (7,5) Viterbi decoder.
package viterbi_pkg;

  localparam int unsigned K          = 3;
  localparam int unsigned NUM_STATES = 4;
  localparam int unsigned BM_W       = 2;
  localparam int unsigned PM_W       = 6;

  typedef logic [1:0]      state_t;
  typedef logic [PM_W-1:0] pm_t;

  // Expected encoder output XY for input b leaving state pred={s1,s0}: X=b^s1^s0 (g0), Y=b^s0 (g1).
  function automatic logic [1:0] exp_pair(state_t pred, logic b);
    return {b ^ pred[1] ^ pred[0], b ^ pred[0]};
  endfunction

endpackage

// File: rtl/viterbi_acs_cell.sv
// Single add-compare-select butterfly half: two candidate sums, keep the smaller, ties to pred 0.
module acs_cell #(
  parameter int unsigned PM_W = 6
) (
  input  logic [PM_W-1:0] pm0,
  input  logic [PM_W-1:0] pm1,
  input  logic [1:0]      bm0,
  input  logic [1:0]      bm1,
  output logic [PM_W:0]   sel,
  output logic            dec
);
  import viterbi_pkg::*;

  logic [PM_W:0] cand0;
  logic [PM_W:0] cand1;

  always_comb begin
    cand0 = {1'b0, pm0} + {{(PM_W - 1){1'b0}}, bm0};
    cand1 = {1'b0, pm1} + {{(PM_W - 1){1'b0}}, bm1};
    dec   = (cand1 < cand0);
    sel   = dec ? cand1 : cand0;
  end

endmodule

// File: rtl/viterbi_acs_unit.sv
// ACS stage: four acs_cells, saturate, joint MSB normalisation, output registers.
// Optional feature: define ACS_BEST_STATE_EN to add the registered best_state output.
module viterbi_acs_unit #(
  parameter int unsigned PM_W     = 6,
  parameter int unsigned INIT_BIG = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic [1:0]          bm00,
  input  logic [1:0]          bm01,
  input  logic [1:0]          bm10,
  input  logic [1:0]          bm11,
  output logic                out_valid,
  output logic [3:0]          dec,
`ifdef ACS_BEST_STATE_EN
  output logic [1:0]          best_state,
`endif
  output logic [4*PM_W-1:0]   pm
);
  import viterbi_pkg::*;

  logic [3:0][1:0] bm_vec;
  logic [PM_W-1:0] pm_q   [NUM_STATES];
  logic [PM_W:0]   sel    [NUM_STATES];
  logic [PM_W-1:0] pm_new [NUM_STATES];
  logic [3:0]      dec_new;
  logic [3:0]      dec_q;
  logic            out_valid_q;
  logic            all_msb;

  assign bm_vec = {bm11, bm10, bm01, bm00};

  for (genvar n = 0; n < NUM_STATES; n++) begin : g_acs
    localparam state_t Ns = state_t'(n);
    localparam state_t P0 = {Ns[0], 1'b0};
    localparam state_t P1 = {Ns[0], 1'b1};
    logic [1:0] bm_p0;
    logic [1:0] bm_p1;

    assign bm_p0 = bm_vec[exp_pair(P0, Ns[1])];
    assign bm_p1 = bm_vec[exp_pair(P1, Ns[1])];

    acs_cell #(
      .PM_W (PM_W)
    ) u_acs (
      .pm0 (pm_q[P0]),
      .pm1 (pm_q[P1]),
      .bm0 (bm_p0),
      .bm1 (bm_p1),
      .sel (sel[n]),
      .dec (dec_new[n])
    );

    assign pm[n*PM_W +: PM_W] = pm_q[n];
  end

  // Saturate first, then drop the shared MSB so metric differences survive unchanged.
  always_comb begin
    all_msb = 1'b1;
    for (int n = 0; n < NUM_STATES; n++) begin
      pm_new[n] = sel[n][PM_W] ? {PM_W{1'b1}} : sel[n][PM_W-1:0];
      all_msb   = all_msb & pm_new[n][PM_W-1];
    end
    if (all_msb) begin
      for (int n = 0; n < NUM_STATES; n++) begin
        pm_new[n][PM_W-1] = 1'b0;
      end
    end
  end

`ifdef ACS_BEST_STATE_EN
  logic [1:0]      best_d;
  logic [1:0]      best_q;
  logic [PM_W-1:0] best_val;

  always_comb begin
    best_d   = 2'd0;
    best_val = pm_new[0];
    for (int n = 1; n < NUM_STATES; n++) begin
      if (pm_new[n] < best_val) begin
        best_d   = 2'(n);
        best_val = pm_new[n];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_q <= 2'd0;
    end else if (start) begin
      best_q <= 2'd0;
    end else if (in_valid) begin
      best_q <= best_d;
    end
  end

  assign best_state = best_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NUM_STATES; n++) begin
        pm_q[n] <= (n == 0) ? '0 : PM_W'(INIT_BIG);
      end
      dec_q       <= 4'd0;
      out_valid_q <= 1'b0;
    end else if (start) begin
      for (int n = 0; n < NUM_STATES; n++) begin
        pm_q[n] <= (n == 0) ? '0 : PM_W'(INIT_BIG);
      end
      out_valid_q <= 1'b0;
    end else if (in_valid) begin
      for (int n = 0; n < NUM_STATES; n++) begin
        pm_q[n] <= pm_new[n];
      end
      dec_q       <= dec_new;
      out_valid_q <= 1'b1;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign dec       = dec_q;
  assign out_valid = out_valid_q;

endmodule
